// File: rtl/instr_encoder.sv
// instr_encoder: packs {aluop, rd, rs1, rs2, imm} into RV32I words and streams them to IMEM.
// Build option ENC_RANGE_CHECK_EN: out-of-range immediates encode as nop and raise err.
module instr_encoder #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0,
   parameter int DEPTH     = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_aluop,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [31:0]       in_imm,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [31:0]       out_instr,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   count
);

   localparam logic [31:0]       NOP_WORD  = 32'h0000_0013;
   localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_J} fmt_t;

   state_t              state_reg;
   logic                busy_reg;
   logic                done_reg;
   logic                out_valid_reg;
   logic [ADDR_W-1:0]   out_addr_reg;
   logic [31:0]         out_instr_reg;
   logic                err_reg;
   logic [ADDR_W:0]     count_reg;

   logic [ADDR_W:0]     count_next;
   logic [ADDR_W-1:0]   addr_next;
   logic                accept;
   logic                finish_session;

   logic [13:1]         op_hot;
   logic                op_legal;
   fmt_t                fmt;
   logic [6:0]          opc;
   logic [2:0]          f3;
   logic [6:0]          f7;
   logic [31:0]         shaped_word;
   logic                imm_ok;
   logic                enc_ok;
   logic [31:0]         enc_word;

   // One decode line per defined op code; anything else is illegal.
   generate
      for (genvar gi = 1; gi <= 13; gi++) begin : g_op_hot
         assign op_hot[gi] = (in_aluop == 6'(gi));
      end
   endgenerate

   assign op_legal = |op_hot;

   always_comb begin
      fmt = FMT_R;
      opc = OPC_OP;
      f3  = 3'b000;
      f7  = 7'b0000000;
      case (in_aluop)
         6'h01: f3 = 3'b000;
         6'h02: begin f3 = 3'b000; f7 = 7'b0100000; end
         6'h03: f3 = 3'b001;
         6'h04: begin fmt = FMT_J; opc = OPC_JAL; end
         6'h05: begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = 3'b000; end
         6'h06: f3 = 3'b111;
         6'h07: f3 = 3'b110;
         6'h08: f3 = 3'b100;
         6'h09: begin fmt = FMT_B; opc = OPC_BRANCH; f3 = 3'b100; end
         6'h0A: begin fmt = FMT_B; opc = OPC_BRANCH; f3 = 3'b000; end
         6'h0B: f3 = 3'b101;
         6'h0C: begin fmt = FMT_I; opc = OPC_LOAD; f3 = 3'b010; end
         6'h0D: begin fmt = FMT_S; opc = OPC_STORE; f3 = 3'b010; end
         default: fmt = FMT_R;
      endcase
   end

   always_comb begin
      case (fmt)
         FMT_R:   shaped_word = {f7, in_rs2, in_rs1, f3, in_rd, opc};
         FMT_I:   shaped_word = {in_imm[11:0], in_rs1, f3, in_rd, opc};
         FMT_S:   shaped_word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
         FMT_B:   shaped_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                                 in_imm[4:1], in_imm[11], opc};
         default: shaped_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                 in_rd, opc};
      endcase
   end

`ifdef ENC_RANGE_CHECK_EN
   logic signed [31:0] simm;
   assign simm = $signed(in_imm);

   // Branch and jump offsets are byte offsets to 2-byte aligned targets.
   always_comb begin
      case (fmt)
         FMT_I, FMT_S: imm_ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
         FMT_B:        imm_ok = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !in_imm[0];
         FMT_J:        imm_ok = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !in_imm[0];
         default:      imm_ok = 1'b1;
      endcase
   end
`else
   logic unused_imm;
   assign unused_imm = &{1'b0, in_imm[31:21]};
   assign imm_ok     = 1'b1;
`endif

   assign enc_ok   = op_legal & imm_ok;
   assign enc_word = enc_ok ? shaped_word : NOP_WORD;

   assign in_ready       = busy_reg & (~out_valid_reg | out_ready);
   assign accept         = in_valid & in_ready;
   assign count_next     = count_reg + 1'b1;
   assign addr_next      = BASE_A + count_reg[ADDR_W-1:0];
   assign finish_session = in_last | (count_next == DEPTH_C);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         out_valid_reg <= 1'b0;
         out_addr_reg  <= BASE_A;
         out_instr_reg <= 32'h0;
         err_reg       <= 1'b0;
         count_reg     <= '0;
      end else begin
         if (accept) begin
            out_valid_reg <= 1'b1;
            out_addr_reg  <= addr_next;
            out_instr_reg <= enc_word;
            count_reg     <= count_next;
            if (!enc_ok) begin
               err_reg <= 1'b1;
            end
         end else if (out_ready) begin
            out_valid_reg <= 1'b0;
         end

         // The output register keeps draining independently of the session state.
         case (state_reg)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_reg <= S_RUN;
                  busy_reg  <= 1'b1;
                  done_reg  <= 1'b0;
                  count_reg <= '0;
                  err_reg   <= 1'b0;
               end
            end
            S_RUN: begin
               if (accept && finish_session) begin
                  state_reg <= S_DONE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg <= S_IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = out_valid_reg;
   assign out_addr  = out_addr_reg;
   assign out_instr = out_instr_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign err       = err_reg;
   assign count     = count_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, stall/restart/reset sequences, a small-DEPTH
// instance with address wrap, and randomized traffic checked by a scoreboard model.
module tb_instr_encoder;

   localparam int DEPTH = 256;
`ifdef ENC_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif
   localparam int K_R = 0, K_I = 1, K_S = 2, K_B = 3, K_J = 4;
   localparam int BND [14] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, -4097,
                                -1048576, 1048574, 1048575, 1048576, -1048578, 3};

   logic        clk = 1'b0;
   logic        rst_n, start, in_valid, in_last, out_ready;
   logic [5:0]  in_aluop;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [31:0] in_imm;
   logic        in_ready, out_valid, busy, done, err;
   logic [7:0]  out_addr;
   logic [31:0] out_instr;
   logic [8:0]  count;

   logic        d4_start, d4_in_valid, d4_out_ready;
   logic        d4_in_ready, d4_out_valid, d4_busy, d4_done, d4_err;
   logic [2:0]  d4_out_addr;
   logic [31:0] d4_out_instr;
   logic [3:0]  d4_count;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(8), .BASE_ADDR(0), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_aluop(in_aluop), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_instr(out_instr), .busy(busy), .done(done), .err(err), .count(count));

   instr_encoder #(.ADDR_W(3), .BASE_ADDR(6), .DEPTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(d4_start), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
      .in_aluop(in_aluop), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .in_last(in_last), .out_valid(d4_out_valid), .out_ready(d4_out_ready),
      .out_addr(d4_out_addr), .out_instr(d4_out_instr), .busy(d4_busy), .done(d4_done),
      .err(d4_err), .count(d4_count));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int unsigned bits(input int unsigned v, input int lo, input int n);
      return (v / (32'd1 << lo)) % (32'd1 << n);
   endfunction

   // Reference encoder: field values placed at their RV32I bit positions by multiplication.
   function automatic logic [31:0] model_word(input logic [5:0] op, input logic [4:0] rd,
                                              input logic [4:0] rs1, input logic [4:0] rs2,
                                              input logic [31:0] imm, output bit bad);
      int unsigned u, w, opc, f3, f7, r_d, r_1, r_2;
      int s, kind;
      u = imm; s = $signed(imm);
      r_d = 32'(rd); r_1 = 32'(rs1); r_2 = 32'(rs2);
      bad = 1'b0; f7 = 0; f3 = 0; opc = 0; kind = K_R;
      case (op)
         6'h01: begin opc = 'h33; f3 = 0; end
         6'h02: begin opc = 'h33; f3 = 0; f7 = 'h20; end
         6'h03: begin opc = 'h33; f3 = 1; end
         6'h04: begin opc = 'h6F; kind = K_J; end
         6'h05: begin opc = 'h13; f3 = 0; kind = K_I; end
         6'h06: begin opc = 'h33; f3 = 7; end
         6'h07: begin opc = 'h33; f3 = 6; end
         6'h08: begin opc = 'h33; f3 = 4; end
         6'h09: begin opc = 'h63; f3 = 4; kind = K_B; end
         6'h0A: begin opc = 'h63; f3 = 0; kind = K_B; end
         6'h0B: begin opc = 'h33; f3 = 5; end
         6'h0C: begin opc = 'h03; f3 = 2; kind = K_I; end
         6'h0D: begin opc = 'h23; f3 = 2; kind = K_S; end
         default: bad = 1'b1;
      endcase
      if (RC) begin
         if ((kind == K_I || kind == K_S) && (s < -2048 || s > 2047)) bad = 1'b1;
         if (kind == K_B && (s < -4096 || s > 4094 || s % 2 != 0)) bad = 1'b1;
         if (kind == K_J && (s < -1048576 || s > 1048574 || s % 2 != 0)) bad = 1'b1;
      end
      if (bad) return 32'h0000_0013;
      w = opc + f3 * 4096;
      case (kind)
         K_R: w += r_d * 128 + r_1 * 32768 + r_2 * 1048576 + f7 * 33554432;
         K_I: w += r_d * 128 + r_1 * 32768 + bits(u, 0, 12) * 1048576;
         K_S: w += bits(u, 0, 5) * 128 + r_1 * 32768 + r_2 * 1048576 + bits(u, 5, 7) * 33554432;
         K_B: w += bits(u, 11, 1) * 128 + bits(u, 1, 4) * 256 + r_1 * 32768 + r_2 * 1048576
                 + bits(u, 5, 6) * 33554432 + bits(u, 12, 1) * 32'h8000_0000;
         default: w = opc + r_d * 128 + bits(u, 12, 8) * 4096 + bits(u, 11, 1) * 1048576
                 + bits(u, 1, 10) * 2097152 + bits(u, 20, 1) * 32'h8000_0000;
      endcase
      return w;
   endfunction

   // Scoreboard: session state plus queue of words owed to IMEM.
   typedef struct { int addr; logic [31:0] instr; } word_t;
   word_t q[$];
   word_t exp_w;
   bit    m_busy = 0, m_done = 0, m_err = 0, m_free, m_bad;
   int    m_count = 0;
   logic [31:0] m_word;

   always @(negedge clk) begin
      m_free = (q.size() == 0) || out_ready;
      if (mon_en) begin
         check("mon_out_valid", 32'(out_valid), 32'(q.size() != 0));
         check("mon_in_ready", 32'(in_ready), 32'(m_busy && m_free));
         check("mon_busy", 32'(busy), 32'(m_busy));
         check("mon_done", 32'(done), 32'(m_done));
         check("mon_err", 32'(err), 32'(m_err));
         check("mon_count", 32'(count), m_count);
      end
      if (q.size() != 0 && out_ready) begin
         exp_w = q.pop_front();
         if (mon_en) begin
            $display("word addr=%0d instr=%h", out_addr, out_instr);
            check("mon_addr", 32'(out_addr), exp_w.addr);
            check("mon_instr", out_instr, exp_w.instr);
         end
      end
      if (!rst_n) begin
         m_busy = 0; m_done = 0; m_err = 0; m_count = 0;
         q.delete();
      end else if (!m_busy) begin
         if (start) begin
            m_busy = 1; m_done = 0; m_err = 0; m_count = 0;
         end
      end else if (in_valid && m_free) begin
         m_word = model_word(in_aluop, in_rd, in_rs1, in_rs2, in_imm, m_bad);
         q.push_back('{m_count % 256, m_word});
         m_count++;
         if (m_bad) m_err = 1;
         if (in_last || m_count == DEPTH) begin
            m_busy = 0; m_done = 1;
         end
      end
   end

   typedef struct {
      logic [5:0] op; logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
      logic [31:0] imm; logic last; logic [31:0] exp; logic exp_err;
   } vec_t;
   vec_t tbl [9];

   task automatic drive(input vec_t v);
      in_aluop = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
      in_imm = v.imm; in_last = v.last;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid), 0);
      check({tag, "_out_addr"}, 32'(out_addr), 0);
      check({tag, "_out_instr"}, out_instr, 0);
      check({tag, "_count"}, 32'(count), 0);
      check({tag, "_err"}, 32'(err), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_in_ready"}, 32'(in_ready), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{6'h01, 5'd3, 5'd1, 5'd2, 32'd0,          1'b0, 32'h002081B3, 1'b0};
      tbl[1] = '{6'h0D, 5'd0, 5'd1, 5'd2, 32'd8,          1'b0, 32'h0020A423, 1'b0};
      tbl[2] = '{6'h02, 5'd5, 5'd6, 5'd7, 32'd0,          1'b0, 32'h407302B3, 1'b0};
      tbl[3] = '{6'h0C, 5'd2, 5'd3, 5'd0, 32'd16,         1'b0, 32'h0101A103, 1'b0};
      tbl[4] = '{6'h05, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF,  1'b0, 32'hFFF00093, 1'b0};
      tbl[5] = '{6'h0A, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC,  1'b0, 32'hFE000EE3, 1'b0};
      tbl[6] = '{6'h05, 5'd0, 5'd0, 5'd0, 32'd4096,       1'b0, 32'h00000013, RC};
      tbl[7] = '{6'h3F, 5'd1, 5'd2, 5'd3, 32'd0,          1'b0, 32'h00000013, 1'b1};
      tbl[8] = '{6'h04, 5'd1, 5'd0, 5'd0, 32'd8,          1'b1, 32'h008000EF, 1'b1};

      rst_n = 0; start = 0; in_valid = 0; out_ready = 0;
      d4_start = 0; d4_in_valid = 0; d4_out_ready = 0;
      drive(tbl[0]);
      repeat (3) tick();
      mon_en = 1;
      check_reset("rst");
      check("rst_d4_addr", 32'(d4_out_addr), 6);
      rst_n = 1;
      tick();
      in_valid = 1;
      tick();
      check("idle_in_ready", 32'(in_ready), 0);
      in_valid = 0;

      start = 1; tick(); start = 0;
      check("start_busy", 32'(busy), 1);
      check("start_count", 32'(count), 0);
      out_ready = 1;
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i]);
         in_valid = 1;
         tick();
         $display("vec %0d op=%h imm=%h -> addr=%0d instr=%h err=%0d",
                  i, tbl[i].op, tbl[i].imm, out_addr, out_instr, err);
         check("tbl_instr", out_instr, tbl[i].exp);
         check("tbl_addr", 32'(out_addr), i);
         check("tbl_valid", 32'(out_valid), 1);
         check("tbl_err", 32'(err), 32'(tbl[i].exp_err));
      end
      in_valid = 0; in_last = 0;
      check("last_done", 32'(done), 1);
      check("last_in_ready", 32'(in_ready), 0);
      tick();
      check("drain_valid", 32'(out_valid), 0);
      check("drain_err_sticky", 32'(err), 1);

      start = 1; tick(); start = 0;
      check("restart_busy", 32'(busy), 1);
      check("restart_err", 32'(err), 0);
      check("restart_done", 32'(done), 0);
      drive(tbl[0]); in_valid = 1; tick(); in_valid = 0;
      check("restart_addr", 32'(out_addr), 0);
      check("restart_instr", out_instr, 32'h002081B3);
      tick();

      out_ready = 0;
      drive(tbl[1]); in_valid = 1; tick();
      drive(tbl[2]);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("stall_instr", out_instr, 32'h0020A423);
         check("stall_addr", 32'(out_addr), 1);
         check("stall_in_ready", 32'(in_ready), 0);
         check("stall_count", 32'(count), 2);
      end
      out_ready = 1; tick();
      check("rel_addr0", 32'(out_addr), 2);
      check("rel_instr0", out_instr, 32'h407302B3);
      drive(tbl[3]); tick();
      check("rel_addr1", 32'(out_addr), 3);
      check("rel_instr1", out_instr, 32'h0101A103);
      in_valid = 0; tick();

      for (int c = 0; c < 600; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         start     = ($urandom_range(0, 9) == 0);
         in_last   = ($urandom_range(0, 19) == 0);
         in_aluop  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 14));
         in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
         case ($urandom_range(0, 2))
            0:       in_imm = $urandom;
            1:       in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            default: in_imm = BND[$urandom_range(0, 13)];
         endcase
         tick();
      end
      in_valid = 0; start = 0; in_last = 0; out_ready = 1;
      tick();

      rst_n = 0; tick(); rst_n = 1; tick();
      start = 1; tick(); start = 0;
      out_ready = 0; drive(tbl[0]); in_valid = 1; tick();
      check("mid_pending", 32'(out_valid), 1);
      rst_n = 0; tick(); rst_n = 1; in_valid = 0;
      check_reset("midrst");
      out_ready = 1; tick();

      d4_start = 1; tick(); d4_start = 0;
      d4_out_ready = 1; drive(tbl[0]); d4_in_valid = 1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("d4_addr", 32'(d4_out_addr), (6 + k) % 8);
         check("d4_instr", d4_out_instr, 32'h002081B3);
         check("d4_count", 32'(d4_count), k + 1);
         check("d4_done", 32'(d4_done), 32'(k == 3));
         check("d4_busy", 32'(d4_busy), 32'(k != 3));
      end
      check("d4_in_ready", 32'(d4_in_ready), 0);
      check("d4_valid", 32'(d4_out_valid), 1);
      check("d4_err", 32'(d4_err), 0);
      d4_in_valid = 0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
